// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares the single L2 request port between the instruction cache and the
// data cache. It runs one request/acknowledge transaction at a time and
// answers with a one-cycle done pulse to the owner. It also keeps grant and
// timeout statistics.
// Optional feature: define L2_ARB_ROUND_ROBIN_EN to break ties in favour of
// the requester that was not the last owner. Without it, the data cache
// always wins a tie.
module l2_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  output logic              i_done,
  output logic              d_done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [31:0]       i_grants,
  output logic [31:0]       d_grants,
  output logic [31:0]       timeouts
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  // Last wait-counter value before the transaction is abandoned. At this
  // point mem_req has been high for exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state, w_state_next;
  logic                r_owner, w_owner_next;        // 1 = data cache owns the port
  logic                r_last_owner, w_last_owner_next;
  logic                r_to_flag, w_to_flag_next;
  logic [7:0]          r_wait, w_wait_next;
  logic                r_mem_req, w_mem_req_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic                r_mem_we, w_mem_we_next;
  logic                r_i_done, w_i_done_next;
  logic                r_d_done, w_d_done_next;
  logic                r_err, w_err_next;
  logic [31:0]         r_i_grants, w_i_grants_next;
  logic [31:0]         r_d_grants, w_d_grants_next;
  logic [31:0]         r_timeouts, w_timeouts_next;
  logic                w_win_d;

  // Arbitration: decide whether the data cache wins when a request is sampled.
  always_comb begin
`ifdef L2_ARB_ROUND_ROBIN_EN
    // On a tie, the requester that did not own the port last time wins.
    w_win_d = d_req & (~i_req | ~r_last_owner);
`else
    // Fixed priority: the data cache always wins.
    w_win_d = d_req;
`endif
  end

  // Next-state and registered-output logic. Pulses default low; everything
  // else holds its value.
  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    w_to_flag_next    = r_to_flag;
    w_wait_next       = r_wait;
    w_mem_req_next    = r_mem_req;
    w_mem_addr_next   = r_mem_addr;
    w_mem_we_next     = r_mem_we;
    w_i_done_next     = 1'b0;
    w_d_done_next     = 1'b0;
    w_err_next        = 1'b0;
    w_i_grants_next   = r_i_grants;
    w_d_grants_next   = r_d_grants;
    w_timeouts_next   = r_timeouts;
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_owner_next    = w_win_d;
          w_mem_addr_next = w_win_d ? d_addr : i_addr;
          w_mem_we_next   = w_win_d & d_we;
          w_wait_next     = 8'd0;
          w_to_flag_next  = 1'b0;
          w_mem_req_next  = 1'b1;
          w_state_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          w_mem_req_next = 1'b0;
          w_i_done_next  = ~r_owner;
          w_d_done_next  = r_owner;
          w_state_next   = S_RESP;
        end else if (r_wait == TO_LAST) begin
          w_mem_req_next = 1'b0;
          w_i_done_next  = ~r_owner;
          w_d_done_next  = r_owner;
          w_err_next     = 1'b1;
          w_to_flag_next = 1'b1;
          w_state_next   = S_RESP;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_RESP: begin
        // Grant counters count only successful transactions.
        if (r_to_flag) begin
          w_timeouts_next = r_timeouts + 32'd1;
        end else if (r_owner) begin
          w_d_grants_next = r_d_grants + 32'd1;
        end else begin
          w_i_grants_next = r_i_grants + 32'd1;
        end
        w_last_owner_next = r_owner;
        w_state_next      = S_IDLE;
      end
      default: begin
        w_state_next   = S_IDLE;
        w_mem_req_next = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b0;
      r_to_flag    <= 1'b0;
      r_wait       <= 8'd0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
      r_err        <= 1'b0;
      r_i_grants   <= 32'd0;
      r_d_grants   <= 32'd0;
      r_timeouts   <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
      r_to_flag    <= w_to_flag_next;
      r_wait       <= w_wait_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_we     <= w_mem_we_next;
      r_i_done     <= w_i_done_next;
      r_d_done     <= w_d_done_next;
      r_err        <= w_err_next;
      r_i_grants   <= w_i_grants_next;
      r_d_grants   <= w_d_grants_next;
      r_timeouts   <= w_timeouts_next;
    end
  end

  assign i_done   = r_i_done;
  assign d_done   = r_d_done;
  assign err      = r_err;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign mem_we   = r_mem_we;
  assign i_grants = r_i_grants;
  assign d_grants = r_d_grants;
  assign timeouts = r_timeouts;

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Shares the single next-level (L2) request port between the instruction cache and the data cache. Each cache posts a 26-bit line address (address bits [31:6]) when it misses or evicts. The arbiter selects one requester, runs a request/acknowledge transaction on the L2 port, and returns a one-cycle completion pulse to the winner. It also keeps per-requester grant counters and a timeout check for the statistics module.

## Interface
Parameters:
- ADDR_W, 26, line address width (address bits [31:6])
- TIMEOUT, 64, cycles to wait in ISSUE for `mem_ack` before aborting; legal range 2..255

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction-cache request; level, held until `i_done`
- i_addr  in  ADDR_W  instruction-cache line address
- d_req  in  1  data-cache request; level, held until `d_done`
- d_addr  in  ADDR_W  data-cache line address
- d_we  in  1  data-cache write-back (1) or read (0)
- i_done  out  1  one-cycle completion pulse to the instruction cache
- d_done  out  1  one-cycle completion pulse to the data cache
- err  out  1  one-cycle pulse, coincident with `done`, when a transaction timed out
- mem_req  out  1  L2 request valid
- mem_addr  out  ADDR_W  latched address of the granted request
- mem_we  out  1  latched write flag; always 0 for instruction grants
- mem_ack  in  1  one-cycle L2 acknowledge
- i_grants  out  32  number of completed instruction transactions
- d_grants  out  32  number of completed data transactions
- timeouts  out  32  number of aborted transactions

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request present: select a winner, latch `mem_addr` and `mem_we` from the winner, record the owner, clear the wait counter, go to ISSUE.
- ISSUE:
  - `mem_req` is 1 and `mem_addr`/`mem_we` are stable.
  - `mem_ack` = 1: go to RESP.
  - No ack: the wait counter (8-bit) increments. When it reaches TIMEOUT-1 without an ack, set the timeout flag and go to RESP.
- RESP:
  - Pulse the owner's `done`; pulse `err` if the timeout flag is set.
  - Increment the owner's grant counter. Increment `timeouts` instead when the transaction timed out, so grant counters count only successful transactions.
  - Update the last-owner register, then go to IDLE.
- Request sampling:
  - `i_req`/`d_req` are sampled only in IDLE.
  - A request still high in the cycle after `done` counts as a new request.
- `mem_ack` outside ISSUE is ignored.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0 without saturation.
- Outputs are registered. Reset values: every output is 0; the state is IDLE; the last owner is instruction.

## Timing
- A request is seen in IDLE at cycle t.
  - `mem_req` is high from t+1.
  - If `mem_ack` arrives at cycle t+k (k≥1), `done` is high at t+k+1 and the state is IDLE at t+k+2.
- Minimum transaction: 3 cycles. Back-to-back grants are spaced 3 cycles apart.
- Timeout: `mem_req` stays high for exactly TIMEOUT cycles, then `done` and `err` pulse together.
- `mem_req` deasserts in the same edge that enters RESP.
- Both requests in the same IDLE cycle: the winner is chosen by the arbitration policy (Configuration).
- Reset mid-transaction:
  - State returns to IDLE, and `mem_req`/`done` are 0 on the next edge.
  - The pending transaction is discarded with no `done`.
  - Counters clear.
  - A late `mem_ack` after reset is ignored.

## Configuration
- `L2_ARB_ROUND_ROBIN_EN` defined: on a simultaneous request, the requester that was not the last owner wins. After reset the last owner is instruction, so the data cache wins the first tie.
- Not defined: fixed priority. The data cache always wins a tie and the instruction cache is served only when `d_req` is 0. Starvation of the instruction cache is allowed.

## Test plan
- Single I read: `i_req`=1, `i_addr`=0x2ABCDEF at cycle 0, `mem_ack` at cycle 3 -> `mem_addr`=0x2ABCDEF with `mem_we`=0 during cycles 1–3; `i_done` high at cycle 4; `i_grants`=1, `d_grants`=0.
- Tie with round robin: `i_req` and `d_req` held high, `mem_ack` issued 1 cycle after each `mem_req` rises, for 4 transactions -> owners in order D, I, D, I; `d_grants`=`i_grants`=2. Without the macro -> order D, D, D, D.
- D write-back: `d_we`=1, `d_addr`=0x0000040 -> `mem_we`=1 for the whole ISSUE phase; the following I grant shows `mem_we`=0.
- Timeout: TIMEOUT=8, no ack -> `mem_req` high for exactly 8 cycles; `d_done` and `err` pulse together; `timeouts`=1, `d_grants`=0.
- Reset mid-ISSUE: `rst` for 1 cycle while `mem_req`=1, then `mem_ack`=1 in the next cycle -> no `done`, all counters 0, state IDLE, `mem_req`=0.
- Stray ack: `mem_ack` pulsed in IDLE -> no outputs change.
